// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared state encodings, defaults and enable levels for the register bank
package regfile_mp_pkg;

  typedef enum logic {
    REGFILE_CLEAR = 1'b0,
    REGFILE_IDLE  = 1'b1
  } rf_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  // Write enable is active-low on the datapath side
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic HIGH     = 1'b1;
  localparam logic LOW      = 1'b0;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port with write-first bypass and zero-entry mask
module regfile_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              idle_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_i [1<<ADDR_W],
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Priority: clear sweep blanks output, then hardwired zero, then bypass, then array
  always_comb begin
    rd_data_d = mem_i[rd_addr_i];
    if (wr_en_i && (rd_addr_i == wr_addr_i)) rd_data_d = wr_data_i;
    if (ZERO_REG && (rd_addr_i == '0)) rd_data_d = '0;
    if (!idle_i) rd_data_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port architectural register bank with post-reset clear sweep
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     we_,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic idle, wr_en, wr_keep;

  assign idle    = (state_q == REGFILE_IDLE);
  assign wr_en   = idle && (we_ == ENABLE_);
  assign wr_keep = wr_en && !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= REGFILE_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= LOW;
    end else if (state_q == REGFILE_CLEAR) begin
      if (clr_ptr_q == '1) begin
        state_q <= REGFILE_IDLE;
        ready_q <= HIGH;
      end else begin
        clr_ptr_q <= clr_ptr_q + 1'b1;
      end
    end
  end

  // Array has no reset; the sweep is what guarantees zeroed contents
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == REGFILE_CLEAR) mem_q[clr_ptr_q] <= '0;
      else if (wr_keep)             mem_q[wr_addr]   <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk_i    (clk),
      .reset_i  (reset),
      .idle_i   (idle),
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .rd_addr_i(rd_addr[k*ADDR_W +: ADDR_W]),
      .mem_i    (mem_q),
      .rd_data_o(rd_data[k*DATA_W +: DATA_W])
    );
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed table-driven bench for regfile_mp (default and small configurations)
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  wa0;
  logic [31:0] wd0;
  logic        we0_n;
  logic [7:0]  ra0;
  logic [63:0] rd0;
  logic        rdy0;

  logic [2:0]  wa1;
  logic [7:0]  wd1;
  logic        we1_n;
  logic [8:0]  ra1;
  logic [23:0] rd1;
  logic        rdy1;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1'b1)) dut0 (
    .clk(clk), .reset(reset), .wr_addr(wa0), .wr_data(wd0), .we_(we0_n),
    .rd_addr(ra0), .rd_data(rd0), .ready(rdy0)
  );

  regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1'b0)) dut1 (
    .clk(clk), .reset(reset), .wr_addr(wa1), .wr_data(wd1), .we_(we1_n),
    .rd_addr(ra1), .rd_data(rd1), .ready(rdy1)
  );

  typedef struct {
    logic        we_n;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra_a;
    logic [3:0]  ra_b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat32(input int i);
    return (i == 0) ? 32'h0 : 32'(i) * 32'h11111111;
  endfunction

  initial begin
    reset = 1'b1;
    we0_n = 1'b1; wa0 = '0; wd0 = '0; ra0 = '0;
    we1_n = 1'b1; wa1 = '0; wd1 = '0; ra1 = '0;

    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b0, 4'(i), 32'(i) * 32'h11111111, 4'(i), 4'd0, pat32(i), 32'h0});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b1, 4'd0, 32'h0, 4'(i), 4'((i + 1) % 16), pat32(i), pat32((i + 1) % 16)});
    vecs.push_back('{1'b0, 4'd5, 32'hDEADBEEF, 4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 4'd0, 32'h0,        4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 4'd0, 32'h00001234, 4'd0, 4'd0, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 4'd6, 32'h0000AAAA, 4'd6, 4'd7, 32'h66666666, 32'h77777777});
    vecs.push_back('{1'b0, 4'd7, 32'hCAFEF00D, 4'd7, 4'd6, 32'hCAFEF00D, 32'h66666666});
    vecs.push_back('{1'b1, 4'd0, 32'h0,        4'd7, 4'd7, 32'hCAFEF00D, 32'hCAFEF00D});

    repeat (3) tick();
    chk("reset_ready0", {31'b0, rdy0}, 32'h0);
    chk("reset_rd0", rd0[31:0] | rd0[63:32], 32'h0);
    chk("reset_ready1", {31'b0, rdy1}, 32'h0);

    // Release reset; a user write at sweep cycle 2 must not land
    reset = 1'b0;
    ra0 = {4'd3, 4'd3};
    for (int c = 1; c <= 16; c++) begin
      if (c == 2) begin we0_n = 1'b0; wa0 = 4'd3; wd0 = 32'h0000FFFF; end
      else        begin we0_n = 1'b1; end
      tick();
      chk($sformatf("sweep_ready0_c%0d", c), {31'b0, rdy0}, {31'b0, (c >= 16)});
      chk($sformatf("sweep_ready1_c%0d", c), {31'b0, rdy1}, {31'b0, (c >= 8)});
      if (c < 16) chk($sformatf("sweep_rd0_c%0d", c), rd0[31:0] | rd0[63:32], 32'h0);
    end
    we0_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      ra0 = {4'(15 - i), 4'(i)};
      tick();
      chk($sformatf("clear_a%0d", i), rd0[31:0], 32'h0);
      chk($sformatf("clear_b%0d", 15 - i), rd0[63:32], 32'h0);
    end

    foreach (vecs[n]) begin
      we0_n = vecs[n].we_n; wa0 = vecs[n].wa; wd0 = vecs[n].wd;
      ra0 = {vecs[n].ra_b, vecs[n].ra_a};
      tick();
      chk($sformatf("vec%0d_a", n), rd0[31:0], vecs[n].exp_a);
      chk($sformatf("vec%0d_b", n), rd0[63:32], vecs[n].exp_b);
    end
    we0_n = 1'b1;

    // One-cycle reset mid-operation: outputs drop, sweep reruns in full
    ra0 = {4'd6, 4'd7};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready0", {31'b0, rdy0}, 32'h0);
    chk("midrst_rd0", rd0[31:0] | rd0[63:32], 32'h0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("resweep_ready0_c%0d", c), {31'b0, rdy0}, {31'b0, (c >= 16)});
    end
    for (int i = 0; i < 16; i++) begin
      ra0 = {4'(i), 4'(i)};
      tick();
      chk($sformatf("recleared_%0d", i), rd0[31:0] | rd0[63:32], 32'h0);
    end

    chk("p_ready1", {31'b0, rdy1}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      we1_n = 1'b0; wa1 = 3'(i); wd1 = 8'(i + 1) * 8'h11;
      tick();
    end
    we1_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra1 = {3'((i + 2) % 8), 3'((i + 1) % 8), 3'(i)};
      tick();
      for (int k = 0; k < 3; k++)
        chk($sformatf("p_port%0d_addr%0d", k, (i + k) % 8), {24'b0, rd1[k*8 +: 8]},
            {24'b0, 8'(((i + k) % 8) + 1) * 8'h11});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
